// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_add_ctrl_pkg;

  localparam int unsigned SERIAL_ADD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Existing 1-bit full-adder cell shared by the serial adder; purely combinational.
module fullAdder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks one full-adder cell over WIDTH cycles, LSB first,
// with a start/busy/done handshake and back-to-back restart from DONE.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sha_q, sha_d;
  logic [WIDTH-1:0]   shb_q, shb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cell_sum_c;
  logic               cell_cout_c;

  fullAdder u_fa (
    .x    (sha_q[0]),
    .y    (shb_q[0]),
    .cin  (carry_q),
    .sum  (cell_sum_c),
    .cout (cell_cout_c)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Cell sum enters at the MSB; after WIDTH shifts bit 0 sits at sum[0]
        sum_d   = WIDTH'({cell_sum_c, sum_q} >> 1);
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        carry_d = cell_cout_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = cell_cout_c;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8, WIDTH=1 and a WIDTH=16 random sweep.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start1, cin1, busy1, done1, cout1;
  logic [0:0]  a1, b1, sum1;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation from an idle start through the done cycle
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    logic [8:0] ref_v;
    ref_v  = 9'(av) + 9'(bv) + 9'(cv);
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
    tick();
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk({tag, "_busy"}, 64'(busy8), 64'd1);
      chk({tag, "_nodone"}, 64'(done8), 64'd0);
      tick();
    end
    chk({tag, "_done"}, 64'(done8), 64'd1);
    chk({tag, "_busyfall"}, 64'(busy8), 64'd0);
    chk({tag, "_result"}, 64'({cout8, sum8}), 64'(ref_v));
    tick();
    chk({tag, "_donepulse"}, 64'(done8), 64'd0);
    chk({tag, "_hold"}, 64'({cout8, sum8}), 64'(ref_v));
  endtask

  initial begin
    logic [16:0] ref16;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    chk("rst_w1", 64'({busy1, done1, cout1, sum1}), 64'd0);
    chk("rst_w16", 64'({busy16, done16, cout16, sum16}), 64'd0);
    rst = 1'b0;
    tick();

    // Basic additions, including full carry propagation
    op8("t1", 8'h05, 8'h03, 1'b0);
    op8("t2a", 8'hFF, 8'h01, 1'b0);
    op8("t2b", 8'h5A, 8'hA5, 1'b1);
    op8("t2c", 8'hFF, 8'hFF, 1'b1);

    // start held through RUN is ignored; accepted again in the DONE cycle
    start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; cin8 = 1'b0;
    tick();
    a8 = 8'h11; b8 = 8'h11;
    for (int j = 0; j < 8; j++) begin
      chk("t3_busy", 64'(busy8), 64'd1);
      tick();
    end
    chk("t3_done", 64'(done8), 64'd1);
    chk("t3_first", 64'({cout8, sum8}), 64'h008);
    tick();
    start8 = 1'b0; a8 = '0; b8 = '0;
    chk("t3_b2b_busy", 64'(busy8), 64'd1);
    chk("t3_b2b_nodone", 64'(done8), 64'd0);
    for (int j = 0; j < 8; j++) tick();
    chk("t3_second_done", 64'(done8), 64'd1);
    chk("t3_second", 64'({cout8, sum8}), 64'h022);
    tick();

    // Reset mid-RUN aborts; next operation has no stale carry
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_busy", 64'(busy8), 64'd0);
    chk("t4_done", 64'(done8), 64'd0);
    chk("t4_sum", 64'(sum8), 64'd0);
    chk("t4_cout", 64'(cout8), 64'd0);
    op8("t4_after", 8'h01, 8'h00, 1'b0);

    // rst and start together: rst wins, no done ever appears
    rst = 1'b1; start8 = 1'b1; a8 = 8'h33; b8 = 8'h44;
    tick();
    rst = 1'b0; start8 = 1'b0;
    chk("t6_busy", 64'(busy8), 64'd0);
    for (int j = 0; j < 10; j++) begin
      chk("t6_nodone", 64'({busy8, done8}), 64'd0);
      tick();
    end

    // WIDTH=1: single RUN cycle
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("w1_busy", 64'(busy1), 64'd1);
    chk("w1_nodone", 64'(done1), 64'd0);
    tick();
    chk("w1_done", 64'(done1), 64'd1);
    chk("w1_result", 64'({cout1, sum1}), 64'h3);
    tick();
    chk("w1_donepulse", 64'(done1), 64'd0);

    // WIDTH=16 random sweep, each new op started back-to-back from DONE
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    start16 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ref16 = 17'(a16) + 17'(b16) + 17'(cin16);
      tick();
      start16 = 1'b0;
      for (int j = 0; j < 16; j++) tick();
      chk("w16_done", 64'(done16), 64'd1);
      chk("w16_result", 64'({cout16, sum16}), 64'(ref16));
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      start16 = 1'b1;
    end
    start16 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
